// File: rtl/bcd_run_ctrl.sv
// Run/stop/clear sequencer for a cascaded NDIG-digit BCD counter with a prescaled count tick.
// Optional macro LAP_HOLD_EN adds a lap input that freezes the displayed count.
module bcd_run_ctrl #(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 5000000,
    parameter int DIV_W    = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              auto_reload,
`ifdef LAP_HOLD_EN
    input  logic              lap,
`endif
    input  logic [4*NDIG-1:0] limit,
    output logic [4*NDIG-1:0] bcd_out,
    output logic              tick,
    output logic              running,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

    state_t            state;
    logic [DIV_W-1:0]  presc;
    logic [4*NDIG-1:0] cnt;

    // Ripple BCD increment: a digit advances only when every lower digit is 9.
    function automatic logic [4*NDIG-1:0] bcd_inc(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        logic              carry;
        logic [3:0]        d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= '0;
            cnt     <= '0;
            tick    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                presc   <= '0;
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!stop && start) begin
                            state   <= RUN;
                            presc   <= '0;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (presc == PRESC_MAX) begin
                            presc <= '0;
                            tick  <= 1'b1;
                            if (cnt == limit) begin
                                done <= 1'b1;
                                if (auto_reload) begin
                                    cnt <= '0;
                                end else begin
                                    state   <= DONE;
                                    running <= 1'b0;
                                end
                            end else begin
                                cnt <= bcd_inc(cnt);
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        // Prescaler is left untouched so a partial period survives the pause.
                        if (!stop && start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (start) begin
                            state   <= RUN;
                            cnt     <= '0;
                            presc   <= '0;
                            running <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic              lap_q;
    logic              hold;
    logic [4*NDIG-1:0] snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= 1'b0;
            hold  <= 1'b0;
            snap  <= '0;
        end else begin
            lap_q <= lap;
            if (clear) begin
                hold <= 1'b0;
            end else if (lap && !lap_q) begin
                hold <= ~hold;
                snap <= cnt;
            end
        end
    end

    assign bcd_out = hold ? snap : cnt;
`else
    assign bcd_out = cnt;
`endif

endmodule
